// File: rtl/aes_pkg.sv
// Shared constants, types and helpers for the multi-size AES key schedule.
package aes_pkg;

    localparam int KEY_MAX  = 256;
    localparam int NB       = 4;
    localparam int RK_DEPTH = 15;

    typedef enum logic [1:0] {
        KS_128 = 2'b00,
        KS_192 = 2'b01,
        KS_256 = 2'b10,
        KS_BAD = 2'b11
    } key_size_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } state_t;

    // Key length in 32-bit words.
    function automatic logic [3:0] nk_of(key_size_t ks);
        case (ks)
            KS_128:  return 4'd4;
            KS_192:  return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    // Number of cipher rounds.
    function automatic logic [3:0] nr_of(key_size_t ks);
        case (ks)
            KS_128:  return 4'd10;
            KS_192:  return 4'd12;
            default: return 4'd14;
        endcase
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte.
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] result
);

    // Row-major table, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte n occupies bits 8*(255-n)+7 down to 8*(255-n).
    assign result = SBOX[{~value, 3'b111} -: 8];

endmodule

// File: rtl/aes_key_expand_multi.sv
// AES-128/192/256 key expansion, one word per cycle, into a round-key SRAM
// with a registered, bounds-checked read port.
module aes_key_expand_multi #(
    parameter int KEY_MAX  = 256,
    parameter int NB       = 4,
    parameter int RK_DEPTH = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [1:0]          key_size,
    input  logic [KEY_MAX-1:0]  key,
    output logic                busy,
    output logic                en_o,
    output logic                keys_valid,
    output logic                err_o,
    input  logic                rk_rd_en,
    input  logic [3:0]          rk_rd_addr,
    output logic [32*NB-1:0]    rk_rd_data,
    output logic                rk_rd_valid
);

    import aes_pkg::*;

    state_t              state;
    logic [KEY_MAX-1:0]  key_q;        // key words still to be emitted, MSB first
    logic [31:0]         win [8];      // win[0] = w[i-1], win[Nk-1] = w[i-Nk]
    logic [31:0]         asm_q [3];    // first three words of the current round key
    logic [5:0]          word_idx;     // i
    logic [2:0]          phase;        // i mod Nk
    logic [3:0]          nk_q;
    logic [3:0]          nr_q;
    logic [7:0]          rcon;
    logic [32*NB-1:0]    rk_mem [RK_DEPTH];

    logic [31:0] w_prev;
    logic [31:0] w_old;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] t_word;
    logic [31:0] new_word;
    logic [5:0]  last_idx;

    assign w_prev   = win[0];
    assign w_old    = win[nk_q[2:0] - 3'd1];
    assign sub_in   = (phase == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign last_idx = {nr_q, 2'b11};    // 4*(Nr+1) - 1

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .value  (sub_in[8*b +: 8]),
            .result (sub_out[8*b +: 8])
        );
    end

    // Select the schedule transform for the current word position.
    always_comb begin
        // NOTE: default assignment first so no path leaves t_word unassigned (no latch).
        t_word = w_prev;
        if (phase == 3'd0)
            t_word = sub_out ^ {rcon, 24'h0};
        else if (nk_q == 4'd8 && phase == 3'd4)
            t_word = sub_out;
    end

    assign new_word = (word_idx < {2'b00, nk_q}) ? key_q[KEY_MAX-1 -: 32]
                                                 : (w_old ^ t_word);

    // Control FSM, word generator, shift window and round-key assembler.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state      <= ST_IDLE;
            busy       <= 1'b0;
            en_o       <= 1'b0;
            keys_valid <= 1'b0;
            err_o      <= 1'b0;
            key_q      <= '0;
            word_idx   <= '0;
            phase      <= '0;
            nk_q       <= 4'd4;
            nr_q       <= 4'd10;
            rcon       <= 8'h01;
            for (int k = 0; k < 8; k++) win[k] <= '0;
            for (int k = 0; k < 3; k++) asm_q[k] <= '0;
        end else begin
            en_o  <= 1'b0;
            err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        if (key_size_t'(key_size) == KS_BAD) begin
                            err_o <= 1'b1;
                        end else begin
                            key_q      <= key;
                            nk_q       <= nk_of(key_size_t'(key_size));
                            nr_q       <= nr_of(key_size_t'(key_size));
                            busy       <= 1'b1;
                            keys_valid <= 1'b0;
                            word_idx   <= '0;
                            phase      <= '0;
                            rcon       <= 8'h01;
                            state      <= ST_EXPAND;
                        end
                    end
                end
                ST_EXPAND: begin
                    win[0] <= new_word;
                    for (int k = 1; k < 8; k++) win[k] <= win[k-1];
                    key_q <= key_q << 32;
                    if (word_idx[1:0] != 2'd3) asm_q[word_idx[1:0]] <= new_word;
                    if (word_idx >= {2'b00, nk_q} && phase == 3'd0) rcon <= xtime(rcon);
                    phase <= (phase == nk_q[2:0] - 3'd1) ? 3'd0 : phase + 3'd1;
                    if (word_idx == last_idx) state <= ST_DONE;
                    else                      word_idx <= word_idx + 6'd1;
                end
                ST_DONE: begin
                    en_o       <= 1'b1;
                    keys_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Round-key SRAM write: the fourth word completes a round key.
    // NOTE: the SRAM has no reset; keys_valid alone guards its contents.
    always_ff @(posedge clk) begin
        if (state == ST_EXPAND && word_idx[1:0] == 2'd3)
            rk_mem[word_idx[5:2]] <= {asm_q[0], asm_q[1], asm_q[2], new_word};
    end

    // Registered read port with bounds and validity gating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rk_rd_valid <= 1'b0;
            rk_rd_data  <= '0;
        end else begin
            rk_rd_valid <= rk_rd_en;
            if (rk_rd_en)
                rk_rd_data <= (keys_valid && rk_rd_addr <= nr_q) ? rk_mem[rk_rd_addr] : '0;
        end
    end

endmodule

// File: doc/aes_key_expand_multi.md
Name: aes_key_expand_multi

Overview:
Parametrised successor to the fixed AES-128 key schedule inside aes_top. Expands a 128-, 192- or 256-bit cipher key into Nr+1 128-bit round keys, selected per request, one 32-bit word per cycle. Round keys are held in an internal round-key SRAM with a registered read port, which feeds the cipher datapath. Adds a done pulse, a valid status, an error flag and read-side bounds handling.

Parameters:
KEY_MAX, 256, width of key input (max AES key size)
NB, 4, 32-bit words per round key/block
RK_DEPTH, 15, round-key SRAM entries (Nr_max+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  start pulse, sampled only in IDLE
key_size  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
key  in  KEY_MAX  cipher key, MSB-aligned (AES-128 uses key[255:128], AES-192 uses key[255:64])
busy  out  1  expansion in progress
en_o  out  1  one-cycle done pulse
keys_valid  out  1  SRAM holds a complete schedule
err_o  out  1  one-cycle pulse: illegal key_size on en
rk_rd_en  in  1  round-key read request
rk_rd_addr  in  4  round index 0..Nr
rk_rd_data  out  128  round key, registered
rk_rd_valid  out  1  rk_rd_data qualifier

Behaviour:
- Reset (reset low): all outputs 0, FSM to IDLE, Rcon=01. SRAM contents are not cleared. keys_valid is cleared.
- Nk/Nr: 4/10, 6/12, 8/14. Total words 4(Nr+1) = 44/52/60.
- FSM IDLE -> EXPAND -> DONE -> IDLE.
- IDLE: en=1 with a legal size latches key and size, sets busy, clears keys_valid, and moves to EXPAND. en=1 with size 11 pulses err_o and stays in IDLE; keys_valid is unchanged.
- en while busy is ignored; no error is raised.
- EXPAND: with en sampled at edge T, word w[i] is registered at edge T+1+i.
  - i<Nk: w[i] = key word i.
  - Else w[i] = w[i-Nk] ^ t, where:
    - i mod Nk = 0: t = SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0}, then Rcon = xtime(Rcon).
    - Nk=8 and i mod Nk = 4: t = SubWord(w[i-1]).
    - Otherwise: t = w[i-1].
- Last Nk words are held in an 8x32 shift window.
- A 4-word assembler writes round key r = {w[4r],..,w[4r+3]} to SRAM[r] at edge T+4r+4.
- DONE (one cycle): en_o=1, keys_valid=1, busy=0 at edge T+4(Nr+1)+1, i.e. T+45/T+53/T+61. Then returns to IDLE.
- Read: rk_rd_en sampled at edge R gives rk_rd_valid=1 and data at R+1.
  - Data is SRAM[addr] if keys_valid and addr<=Nr_latched; otherwise 128'h0.
  - rk_rd_valid is always 1 the cycle after a request.
- Reads during busy return 0, because keys_valid is low.
- Reset asserted mid-expansion aborts immediately. The partial SRAM is never exposed, since keys_valid stays 0.
- Back-to-back: en on the cycle after en_o is accepted and starts a new schedule.

Decomposition:
- aes_pkg: NB, Nk/Nr lookup function, key_size_t enum, xtime function, RK_DEPTH constant.
- Sub-module aes_sbox (combinational byte S-box), instantiated 4x for SubWord.
- Round-key SRAM is an inferred array local to the block.

Test Plan:
- AES-128, key 5468617473206d79204b756e67204675 -> SRAM[1]=e232fcf191129188b159e4e6d679a293, SRAM[10]=28fddef86da4244accc0a4fe3b316f26, en_o at T+45.
- AES-192 (FIPS-197 A.2), key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> SRAM[12]=e98ba06f448c773c8ecc720401002202, en_o at T+53.
- AES-256 (A.3), key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> SRAM[14]=fe4890d1e6188d0b046df344706c631e, en_o at T+61.
- key_size=11 with en -> err_o one cycle, busy stays 0. Read addr 11 after the AES-128 run -> rk_rd_data=0, rk_rd_valid=1.
- Reset low at T+20 of an AES-256 run -> busy=0 and keys_valid=0 immediately. Reads return 0. A fresh AES-128 run then completes correctly.
- en pulsed mid-expansion is ignored. en on the cycle after en_o starts the next run, ending at T'+45.
